// File: rtl/muldiv_if.sv
// +--------------------------------------------------------------------+
// | muldiv_if : request/result bundle for the sequential mult/div unit |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output busy, done, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_seq.sv
// +--------------------------------------------------------------------+
// | muldiv_seq : 32-bit iterative MULT/MULTU/DIV/DIVU with HI/LO regs  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module muldiv_seq (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_div0;
   logic [31:0] r_mag_b;
   logic [63:0] r_acc;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_sum;
   logic        w_ge;
   logic [31:0] w_sub;
   logic [63:0] w_step;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_signed = ~bus.op[0];
   assign w_mag_a  = (w_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
   assign w_mag_b  = (w_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign w_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mag_b : 32'd0)};
   assign w_ge   = r_acc[63:31] >= {1'b0, r_mag_b};
   assign w_sub  = r_acc[62:31] - r_mag_b;
   assign w_step = r_is_div ? (w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0})
                            : {w_sum, r_acc[31:1]};

   // Divide-by-zero leaves |a| as remainder, so only the quotient is forced
   assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
   assign w_quo  = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
   assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_mag_b  <= 32'd0;
         r_acc    <= 64'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.wr_hi) r_hi <= bus.wdata;
               if (bus.wr_lo) r_lo <= bus.wdata;
               if (bus.start) begin
                  r_is_div <= bus.op[1];
                  r_acc    <= {32'd0, w_mag_a};
                  r_mag_b  <= w_mag_b;
                  r_neg_q  <= w_signed & (bus.a[31] ^ bus.b[31]);
                  r_neg_r  <= w_signed & bus.op[1] & bus.a[31];
                  r_div0   <= bus.op[1] & (bus.b == 32'd0);
                  r_cnt    <= 5'd0;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) r_state <= FIX;
            end
            FIX: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// +--------------------------------------------------------------------+
// | tb_muldiv_seq : directed + random checks against an arithmetic model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_seq;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   n_done;

   muldiv_if bus ();

   muldiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done === 1'b1) n_done++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      h  = 32'd0;
      l  = 32'd0;
      case (op)
         2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
         2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
         2'b10: begin
            if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin sp = sa / sb; l = sp[31:0]; sp = sa % sb; h = sp[31:0]; end
         end
         default: begin
            if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
         end
      endcase
   endfunction

   // Called right after a negedge. Sample s is taken at the negedge following
   // edge T(s-1); the result must first appear at sample 34 (edge T33).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, input int wrbusy_at, input bit wr_with_start);
      logic [31:0] eh, el, lo0;
      int          d0;
      bit          busy_ok;
      model(op, a, b, eh, el);
      lo0     = bus.lo;
      d0      = n_done;
      busy_ok = 1'b1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (wr_with_start) begin
         bus.wr_hi = 1'b1;
         bus.wdata = 32'h5A5A_0F0F;
      end
      for (int s = 1; s <= 35; s++) begin
         @(negedge clk);
         if (s == 1) begin
            bus.start = 1'b0;
            bus.wr_hi = 1'b0;
            bus.a     = $urandom;
            bus.b     = $urandom;
            if (wr_with_start) chk("wr_hi_with_start", bus.hi, 32'h5A5A_0F0F);
         end
         if (s == restart_at) begin
            bus.start = 1'b1;
            bus.op    = 2'b10;
            bus.a     = $urandom;
            bus.b     = $urandom;
         end
         if (s == restart_at + 1) bus.start = 1'b0;
         if (s == wrbusy_at) begin
            bus.wr_lo = 1'b1;
            bus.wdata = 32'hDEAD_BEEF;
         end
         if (s == wrbusy_at + 1) begin
            bus.wr_lo = 1'b0;
            chk("wr_lo_while_busy", bus.lo, lo0);
         end
         if (s <= 33) busy_ok &= (bus.busy === 1'b1) && (bus.done === 1'b0);
         if (s == 34) begin
            // busy spans edges T0..T33 inclusive, 34 edges in all
            chk("busy_window", busy_ok, 1'b1);
            chk("done_pulse", bus.done, 1'b1);
            chk("busy_clear", bus.busy, 1'b0);
            chk("hi", bus.hi, eh);
            chk("lo", bus.lo, el);
         end
         if (s == 35) begin
            chk("done_one_cycle", bus.done, 1'b0);
            chk("hi_hold", bus.hi, eh);
            chk("lo_hold", bus.lo, el);
            chk("done_count", n_done - d0, 1);
         end
      end
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          d0;
      n_cmp = 0; n_bad = 0; n_done = 0;
      rst_n = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = 32'd0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      rst_n = 1'b1;

      // First start after reset is accepted immediately
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
      chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", bus.lo, 32'h0000_0001);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
      run_op(2'b11, 32'd100, 32'd0, 0, 0, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
      chk("div_ovf_lo", bus.lo, 32'h8000_0000);
      chk("div_ovf_hi", bus.hi, 32'd0);
      run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0, 0, 1'b0);
      run_op(2'b01, 32'd5, 32'd6, 10, 0, 1'b0);

      // Register writes in IDLE and while busy
      bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
      @(negedge clk);
      bus.wr_lo = 1'b0;
      chk("wr_lo_idle", bus.lo, 32'h1234);
      run_op(2'b00, 32'h0001_2345, 32'hFFFF_8000, 0, 12, 1'b0);
      run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0123, 0, 0, 1'b1);

      // Reset in the middle of a DIVU
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = n_done;
      repeat (40) @(negedge clk);
      chk("abort_no_done", n_done - d0, 0);
      chk("abort_hi_hold", bus.hi, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            3: ra = 32'($urandom_range(0, 50));
            default: ;
         endcase
         run_op(rop, ra, rb, 0, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
